// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer.
package timer_ctrl_pkg;

    localparam int unsigned SEC_W = 7;
    localparam logic [SEC_W-1:0] MAX_SEC = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Clamp a requested load value to the displayable range.
    function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] v);
        return (v > MAX_SEC) ? MAX_SEC : v;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Command/status bundle between a timer controller and its user.
interface timer_ctrl_if;

    logic                              start;
    logic                              pause;
    logic                              clear;
    logic [timer_ctrl_pkg::SEC_W-1:0]  load_sec;
    logic [timer_ctrl_pkg::SEC_W-1:0]  remaining;
    logic                              running;
    logic                              tick;
    logic                              done;
    logic                              alarm;

    modport master (
        output start, pause, clear, load_sec,
        input  remaining, running, tick, done, alarm
    );

    modport slave (
        input  start, pause, clear, load_sec,
        output remaining, running, tick, done, alarm
    );

endinterface

// File: rtl/timer_ctrl_tick_gen.sv
// Clock-enable tick divider: counts 0..DIV-1 while enabled, pulses tick after the wrap.
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick,
    output logic wrap_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // A synchronous clear also swallows a coincident wrap.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wrap_c = en && (cnt_q == CNT_W'(DIV - 1));
        if (sync_clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (wrap_c) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/timer_ctrl.sv
// Seconds countdown timer: IDLE/RUN/PAUSE/DONE control around a clock-enable tick generator.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_ctrl_if.slave    bus
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    if (DIV < 2) begin : g_bad_div
        $error("timer_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end

    state_e           state_q, state_d;
    logic [SEC_W-1:0] remaining_q, remaining_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             alarm_q, alarm_d;
    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             ready;
    logic             cnt_clr_c;
    logic             wrap_c;
    logic             tick_s;

    // Commands are ignored until the deasserted reset has crossed two flops.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    assign ready = rst_sync_q[1];

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_q == ST_RUN),
        .sync_clr (cnt_clr_c),
        .tick     (tick_s),
        .wrap_c   (wrap_c)
    );

    // Command priority: clear, then (re)load or resume, then tick/pause.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        cnt_clr_c   = 1'b0;
        if (ready) begin
            if (bus.clear) begin
                state_d     = ST_IDLE;
                remaining_d = '0;
                cnt_clr_c   = 1'b1;
            end else if (bus.start && (state_q == ST_IDLE || state_q == ST_DONE ||
                                       (state_q == ST_PAUSE && remaining_q == '0))) begin
                remaining_d = sat_sec(bus.load_sec);
                cnt_clr_c   = 1'b1;
                if (remaining_d == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end else if (bus.start && state_q == ST_PAUSE) begin
                state_d = ST_RUN;
            end else if (state_q == ST_RUN) begin
                if (wrap_c && remaining_q != '0) begin
                    remaining_d = remaining_q - SEC_W'(1);
                    if (remaining_d == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end
                end else if (bus.pause) begin
                    state_d = ST_PAUSE;
                end
            end
        end
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q  <= 2'b00;
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            running_q   <= running_d;
            done_q      <= done_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.remaining = remaining_q;
    assign bus.running   = running_q;
    assign bus.tick      = tick_s;
    assign bus.done      = done_q;
    assign bus.alarm     = alarm_q;

endmodule
